// File: rtl/sr595_tx.sv
`default_nettype none
// ============================================================================
// Module   : sr595_tx
// Purpose  : Serial transmitter for a 74HC595-style shift/latch chain.
//            Accepts a parallel word over valid/ready, shifts it out MSB-first
//            on sx/sclk, then strobes rclk. After reset an all-zero clear
//            frame is sent so the external latches start from a known state.
// Revision : 1.0 - initial release
// ============================================================================
module sr595_tx #(
  parameter int WIDTH = 16,
  parameter int DIV   = 2
) (
  input  logic             clk_6144,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sx,
  output logic             sclk,
  output logic             rclk,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shown
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_DIV_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] C_BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [BW-1:0]    bit_q,   bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] frame_q, frame_d;
  logic [WIDTH-1:0] shown_q, shown_d;
  // Set by reset so the first non-reset edge is the clear frame's E0
  // rather than its second SETUP cycle.
  logic             hold_q,  hold_d;
  logic             done_q,  done_d;
  logic             sx_q,    sx_d;
  logic             sclk_q,  sclk_d;
  logic             rclk_q,  rclk_d;
  logic             ready_q, ready_d;
  logic             busy_q,  busy_d;

  logic             w_div_end;
  assign w_div_end = (cnt_q == C_DIV_LAST);

  // Next-state logic; pin outputs are derived from the next state so they
  // leave the block straight from flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    shown_d = shown_q;
    hold_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          bit_d   = C_BIT_LAST;
          shreg_d = load_data;
          frame_d = load_data;
        end
      end
      S_SETUP: begin
        if (hold_q) begin
          cnt_d = '0;
        end else if (w_div_end) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (w_div_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q << 1;
          if (bit_q == '0) begin
            state_d = S_LATCH;
          end else begin
            bit_d   = bit_q - BW'(1);
            state_d = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_LATCH: begin
        if (w_div_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          shown_d = frame_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    sx_d    = ((state_d == S_SETUP) || (state_d == S_HIGH)) ? shreg_d[WIDTH-1] : 1'b0;
    sclk_d  = (state_d == S_HIGH);
    rclk_d  = (state_d == S_LATCH);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; reset arms an all-zero clear frame.
  always_ff @(posedge clk_6144) begin
    if (reset) begin
      state_q <= S_SETUP;
      cnt_q   <= '0;
      bit_q   <= C_BIT_LAST;
      shreg_q <= '0;
      frame_q <= '0;
      shown_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      sx_q    <= 1'b0;
      sclk_q  <= 1'b0;
      rclk_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      frame_q <= frame_d;
      shown_q <= shown_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      sx_q    <= sx_d;
      sclk_q  <= sclk_d;
      rclk_q  <= rclk_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign load_ready = ready_q;
  assign sx         = sx_q;
  assign sclk       = sclk_q;
  assign rclk       = rclk_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign shown      = shown_q;

endmodule
`default_nettype wire

// File: doc/sr595_tx.md
# sr595_tx

Serial output transmitter for an external 74HC595-style shift/latch register chain. It drives coin counters, lamps and board LEDs from the arcade core on the Nano/Trion boards. It is the output-side counterpart of the serial DIP-switch input chain: the core hands over a parallel word through a valid/ready handshake, and the block shifts it out MSB-first on `sx`/`sclk`, then strobes `rclk`. After reset the block clears the external latches by sending one all-zero frame.

## Interface
Parameters:
- `WIDTH`, 16: bits per frame (number of chained 595 outputs); must be ≥2.
- `DIV`, 2: clk_6144 cycles per half-period of `sclk` and per `rclk` pulse; must be ≥1.

Ports:
- `clk_6144` in 1: single clock. All logic runs on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `load_data` in WIDTH: word to transmit. Sampled only at acceptance.
- `load_valid` in 1: request to transmit `load_data`.
- `load_ready` out 1: block idle and able to accept a word.
- `sx` out 1: serial data to the 595 SER pin.
- `sclk` out 1: shift clock to the 595 SRCLK pin.
- `rclk` out 1: latch strobe to the 595 RCLK pin.
- `busy` out 1: frame in progress. Equals `~load_ready`.
- `done` out 1: one-cycle pulse at the end of each frame.
- `shown` out WIDTH: copy of the word currently latched at the 595 outputs.

## Operation
- All outputs are registered.
- **States:**
  - IDLE: `load_ready`=1, `sx`=`sclk`=`rclk`=0.
  - SETUP: `sclk`=0 and `sx`=current bit, for DIV cycles.
  - HIGH: `sclk`=1, `sx` held, for DIV cycles.
  - LATCH: `sclk`=0, `sx`=0, `rclk`=1, for DIV cycles.
- **Acceptance:** at an edge where `load_valid`&`load_ready`=1, the block copies `load_data` into the shift register and sets the bit counter to WIDTH-1. The state goes IDLE→SETUP.
- **SETUP→HIGH:** after DIV cycles.
- **HIGH end:** after DIV cycles, the shift register shifts left by one.
  - If the bit counter is 0, go to LATCH.
  - Otherwise decrement the bit counter and go to SETUP.
- **LATCH end:** after DIV cycles, go to IDLE. At that same edge, pulse `done`=1 for one cycle and set `shown` to the frame word.
- **Bit order:** MSB first. The last bit shifted (`data[0]`) lands on 595 output QA of the first chip.
- **Reset:**
  - While `reset`=1 at an edge: `sx`=`sclk`=`rclk`=0, `load_ready`=0, `busy`=1, `done`=0, `shown`=0. The shift register is loaded with 0 and the state is forced to SETUP with the counters cleared.
  - The first edge with `reset`=0 is E0 of an automatic all-zero clear frame.
  - `load_valid` is ignored until the clear frame finishes.
- **Reset mid-frame:** the frame is aborted, no `done` is issued, `shown` is cleared, and the clear frame restarts.
- **Input stability:** changes to `load_data` or `load_valid` after acceptance have no effect on the frame in progress.

## Timing
- E0 is the acceptance edge (or the first non-reset edge for the clear frame). "Edge n" means the registered value after edge E0+n.
- **Bit k** (k=0 is the MSB):
  - `sx`=`data[WIDTH-1-k]` from edge 2·DIV·k up to edge 2·DIV·(k+1).
  - `sclk`=1 from edge 2·DIV·k+DIV up to edge 2·DIV·(k+1).
  - Each bit therefore has DIV cycles of setup and DIV cycles of hold around its `sclk` rise.
- **Latch:** `rclk`=1 from edge 2·DIV·WIDTH up to edge 2·DIV·WIDTH+DIV.
- **Frame end:** at edge 2·DIV·WIDTH+DIV, `done`=1 for one cycle, `load_ready`=1, and `shown` is updated.
- **Frame length:** 2·DIV·WIDTH+DIV cycles; 66 for the defaults.
- **Back-to-back period** with `load_valid` held high: 2·DIV·WIDTH+DIV+1 cycles (67 for the defaults). The next acceptance is at the edge after `load_ready` rises.
- `sclk` and `rclk` are never high in the same cycle.
- `sx` changes only while `sclk`=0.

## Test plan
1. Release reset with `load_valid`=0, defaults → clear frame: 16 `sclk` pulses with `sx`=0, then `rclk` high for 2 cycles. `done` pulses at edge 66, `shown`=16'h0000, then `load_ready`=1.
2. After the clear frame, accept 16'hA5C3 (DIV=2) → `sx` sequence 1010 0101 1100 0011 with each bit stable over its `sclk` high. `rclk` is high at edges 64–65, `done` at edge 66, `shown`=16'hA5C3.
3. Hold `load_valid`=1 with words 16'h0001 then 16'hFFFF → acceptances exactly 67 cycles apart. `shown` goes 16'h0001 then 16'hFFFF. No extra `sclk` pulses between frames.
4. Assert `reset` for 1 cycle at edge 20 of a 16'hFFFF frame → no `done` for that frame, `shown`=0. A full zero frame follows, and `load_ready` returns 66 cycles after reset drops.
5. Parameters WIDTH=8, DIV=1, word 8'h81 → `sx`=1,0,0,0,0,0,0,1 with one-cycle `sclk` highs. `rclk` is high at edge 16 only, `done` at edge 17, period 18.
6. Change `load_data` from 16'h1234 to 16'hFFFF one cycle after acceptance while holding `load_valid` → the frame transmits 16'h1234. 16'hFFFF is accepted only at the next `load_ready`.
